simmem_release_arbiter: RTL and testbench

// - Consumes the releasable-entry multihot produced by the delay bank; each cycle grants at most
//   one releasable entry, round-robin, and presents its entry index to the response bank.
// - On the output handshake, returns a one-hot "released" pulse so the delay bank clears that bit.
// - Sits between the delay bank (upstream) and the response-bank read port (downstream).
//

---
 rtl/simmem_pkg.sv | 17 +
 rtl/simmem_rr_picker.sv | 40 ++++
 rtl/simmem_release_arbiter.sv | 124 ++++++++++++
 tb/tb_simmem_release_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/simmem_pkg.sv
// Shared sizing and types for the simulated-memory response path.
// Latency: none (package of constants and types only).
// Backpressure: not applicable.
package simmem_pkg;

    localparam int WRspBankCapa = 8;
    localparam int WRspBankIdxW = (WRspBankCapa > 1) ? $clog2(WRspBankCapa) : 1;

    typedef logic [WRspBankIdxW-1:0] wrsp_bank_idx_t;

    // Presentation state of the release arbiter; the encoding doubles as rel_valid_o.
    typedef enum logic {
        REL_IDLE    = 1'b0,
        REL_PRESENT = 1'b1
    } rel_state_e;

endpackage

// File: rtl/simmem_rr_picker.sv
// Round-robin picker: first set request bit at or after ptr_i, wrapping to bit 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a pick is consumed.
module simmem_rr_picker #(
    parameter int NumEntries = 8,
    parameter int IdxW       = 3
) (
    input  logic [NumEntries-1:0] req_i,
    input  logic [IdxW-1:0]       ptr_i,
    output logic [IdxW-1:0]       grant_idx_o,
    output logic                  any_valid_o
);

    logic [IdxW-1:0] hi_idx;
    logic [IdxW-1:0] lo_idx;
    logic            hi_vld;
    logic            lo_vld;

    // Scan downwards so the lowest qualifying index wins in both the at-or-above-pointer and wrapped search.
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        hi_vld = 1'b0;
        lo_vld = 1'b0;
        for (int i = NumEntries - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                lo_idx = IdxW'(i);
                lo_vld = 1'b1;
                if (IdxW'(i) >= ptr_i) begin
                    hi_idx = IdxW'(i);
                    hi_vld = 1'b1;
                end
            end
        end
    end

    assign grant_idx_o = hi_vld ? hi_idx : lo_idx;
    assign any_valid_o = lo_vld;

endmodule

// File: rtl/simmem_release_arbiter.sv
// Grants one releasable response entry per cycle, round-robin; optional stats under SIMMEM_RELEASE_STATS_EN.
// Latency: release bit rising while idle -> rel_valid_o one cycle later; back-to-back grants sustain one per cycle.
// Backpressure: rel_idx_o held stable while rel_ready_i is low; released_onehot_o pulses on the handshake only.
module simmem_release_arbiter
    import simmem_pkg::*;
#(
    parameter int NumEntries = WRspBankCapa,
    parameter int IdxW       = (NumEntries > 1) ? $clog2(NumEntries) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NumEntries-1:0] release_en_i,
    output logic [NumEntries-1:0] released_onehot_o,
    output logic                  rel_valid_o,
    output logic [IdxW-1:0]       rel_idx_o,
`ifdef SIMMEM_RELEASE_STATS_EN
    output logic [31:0]           rel_count_o,
    output logic [31:0]           stall_cycles_o,
`endif
    input  logic                  rel_ready_i
);

    rel_state_e            state_q;
    rel_state_e            state_d;
    logic [IdxW-1:0]       rel_idx_q;
    logic [IdxW-1:0]       rel_idx_d;
    logic [IdxW-1:0]       ptr_q;
    logic [IdxW-1:0]       ptr_d;
    logic [IdxW-1:0]       idx_inc;
    logic [IdxW-1:0]       grant_idx;
    logic                  any_valid;
    logic                  hs;
    logic [NumEntries-1:0] cand;

    assign hs      = (state_q == REL_PRESENT) && rel_ready_i;
    assign idx_inc = (rel_idx_q == IdxW'(NumEntries - 1)) ? '0 : rel_idx_q + IdxW'(1);
    assign ptr_d   = hs ? idx_inc : ptr_q;

    // The delay bank clears a released bit one edge late, so the entry handshaken now is masked out.
    assign cand = release_en_i & ~released_onehot_o;

    // The pointer already advanced past the entry just released, so a back-to-back grant moves on.
    simmem_rr_picker #(
        .NumEntries (NumEntries),
        .IdxW       (IdxW)
    ) u_picker (
        .req_i       (cand),
        .ptr_i       (ptr_d),
        .grant_idx_o (grant_idx),
        .any_valid_o (any_valid)
    );

    // State, presented index and round-robin pointer registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= REL_IDLE;
            rel_idx_q <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            rel_idx_q <= rel_idx_d;
            ptr_q     <= ptr_d;
        end
    end

    // Next state: grant from idle, hold while stalled, regrant or go idle on a handshake.
    always_comb begin
        state_d   = state_q;
        rel_idx_d = rel_idx_q;
        case (state_q)
            REL_IDLE: begin
                if (any_valid) begin
                    state_d   = REL_PRESENT;
                    rel_idx_d = grant_idx;
                end
            end
            REL_PRESENT: begin
                if (hs) begin
                    if (any_valid) begin
                        rel_idx_d = grant_idx;
                    end else begin
                        state_d = REL_IDLE;
                    end
                end
            end
            default: state_d = REL_IDLE;
        endcase
    end

    // Outputs: valid mirrors the state, released pulse is the same-cycle decode of the handshake.
    always_comb begin
        rel_valid_o       = (state_q == REL_PRESENT);
        rel_idx_o         = rel_idx_q;
        released_onehot_o = hs ? (NumEntries'(1) << rel_idx_q) : '0;
    end

`ifdef SIMMEM_RELEASE_STATS_EN
    logic [31:0] rel_count_q;
    logic [31:0] stall_q;

    // Handshake count wraps freely; stall count sticks at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rel_count_q <= '0;
            stall_q     <= '0;
        end else begin
            if (hs) begin
                rel_count_q <= rel_count_q + 32'd1;
            end
            if ((state_q == REL_PRESENT) && !rel_ready_i && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign rel_count_o    = rel_count_q;
    assign stall_cycles_o = stall_q;
`endif

    // A presented entry must stay releasable until it is accepted.
    a_presented_sticky: assert property (@(posedge clk_i) disable iff (rst_i)
        rel_valid_o |-> release_en_i[rel_idx_o]);

endmodule

// File: tb/tb_simmem_release_arbiter.sv
module tb_simmem_release_arbiter;

    localparam int N  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  release_en;
    logic [N-1:0]  onehot;
    logic          valid;
    logic [IW-1:0] idx;
    logic          ready;
`ifdef SIMMEM_RELEASE_STATS_EN
    logic [31:0]   rel_count;
    logic [31:0]   stall_cycles;
`endif

    always #5 clk = ~clk;

    simmem_release_arbiter #(
        .NumEntries (N),
        .IdxW       (IW)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .release_en_i      (release_en),
        .released_onehot_o (onehot),
        .rel_valid_o       (valid),
        .rel_idx_o         (idx),
`ifdef SIMMEM_RELEASE_STATS_EN
        .rel_count_o       (rel_count),
        .stall_cycles_o    (stall_cycles),
`endif
        .rel_ready_i       (ready)
    );

    // Reference: delay-bank contents plus the arbiter's observable promise.
    logic [N-1:0] pend;
    bit           m_valid;
    int           m_idx;
    int           m_ptr;
    int unsigned  m_cnt;
    int unsigned  m_stall;
    int           grant_log[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First pending entry walking upward from 'from', modulo N; -1 if none.
    function automatic int pick(input logic [N-1:0] c, input int from);
        logic [N-1:0] s;
        for (int k = 0; k < N; k++) begin
            s = c >> ((from + k) % N);
            if (s[0]) return (from + k) % N;
        end
        return -1;
    endfunction

    task automatic step(input logic [N-1:0] add, input logic rdy,
                        output logic o_valid, output logic [IW-1:0] o_idx, output logic [N-1:0] o_oh);
        logic [N-1:0] exp_oh;
        bit           hs;
        int           g;
        @(negedge clk);
        pend       = pend | add;
        release_en = pend;
        ready      = rdy;
        #1;
        o_valid = valid;
        o_idx   = idx;
        o_oh    = onehot;
        hs      = m_valid && rdy;
        exp_oh  = hs ? (N'(1) << m_idx) : '0;
        chk("valid", valid, m_valid);
        if (m_valid) chk("idx", idx, m_idx);
        chk("released", onehot, exp_oh);
`ifdef SIMMEM_RELEASE_STATS_EN
        chk("rel_count", rel_count, m_cnt);
        chk("stall_cycles", stall_cycles, m_stall);
`endif
        if (hs) begin
            grant_log.push_back(m_idx);
            m_ptr = (m_idx + 1) % N;
            m_cnt++;
        end
        if (m_valid && !rdy && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (!m_valid || hs) begin
            g       = pick(pend & ~exp_oh, m_ptr);
            m_valid = (g >= 0);
            if (g >= 0) m_idx = g;
        end
        @(posedge clk);
        pend = pend & ~exp_oh;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        ready      = 1'b0;
        release_en = pend;
        #1;
        chk("rst_released", onehot, 0);
        @(posedge clk);
        pend    = '0;
        m_valid = 0;
        m_ptr   = 0;
        m_idx   = 0;
        m_cnt   = 0;
        m_stall = 0;
        @(negedge clk);
        rst        = 1'b0;
        release_en = '0;
        #1;
        chk("post_rst_valid", valid, 0);
        chk("post_rst_released", onehot, 0);
`ifdef SIMMEM_RELEASE_STATS_EN
        chk("post_rst_count", rel_count, 0);
        chk("post_rst_stall", stall_cycles, 0);
`endif
    endtask

    initial begin
        logic          ov;
        logic [IW-1:0] oi;
        logic [N-1:0]  oo;

        rst = 1'b1; ready = 1'b0; release_en = '0; pend = '0;
        m_valid = 0; m_idx = 0; m_ptr = 0; m_cnt = 0; m_stall = 0;
        repeat (2) @(posedge clk);
        do_reset();

        // Quiet after reset.
        repeat (10) step('0, 1'b1, ov, oi, oo);

        // Two entries released on consecutive cycles, ascending.
        step(8'h24, 1'b1, ov, oi, oo); chk("dirA_latency_valid", ov, 0);
        step('0, 1'b1, ov, oi, oo);    chk("dirA_idx0", oi, 2); chk("dirA_oh0", oo, 8'h04);
        step('0, 1'b1, ov, oi, oo);    chk("dirA_idx1", oi, 5); chk("dirA_oh1", oo, 8'h20);
        step('0, 1'b1, ov, oi, oo);    chk("dirA_idle", ov, 0);

        // Stall: index held, no pulse, single pulse on accept, no regrant.
        step(8'h01, 1'b0, ov, oi, oo);
        repeat (5) step('0, 1'b0, ov, oi, oo);
        chk("stall_valid", ov, 1); chk("stall_idx", oi, 0); chk("stall_oh", oo, 0);
        step('0, 1'b1, ov, oi, oo);    chk("stall_accept_oh", oo, 8'h01);
        step('0, 1'b1, ov, oi, oo);    chk("no_regrant", ov, 0);

        // Wrap: release 6, then 7 and 0 pending.
        step(8'h40, 1'b1, ov, oi, oo);
        step('0, 1'b1, ov, oi, oo);    chk("wrap_idx6", oi, 6);
        step(8'h81, 1'b1, ov, oi, oo);
        step('0, 1'b1, ov, oi, oo);    chk("wrap_idx7", oi, 7);
        step('0, 1'b1, ov, oi, oo);    chk("wrap_idx0", oi, 0);
        step('0, 1'b1, ov, oi, oo);    chk("wrap_idle", ov, 0);

        // Reset while presenting with ready low.
        step(8'h10, 1'b1, ov, oi, oo);
        step('0, 1'b0, ov, oi, oo);    chk("pre_rst_present", ov, 1);
        do_reset();

        // Fairness from pointer 0 with every entry refilled.
        grant_log.delete();
        repeat (17) step(8'hFF, 1'b1, ov, oi, oo);
        chk("fair_count", grant_log.size(), 16);
        for (int i = 0; i < 16 && i < grant_log.size(); i++)
            chk("fair_order", grant_log[i], i % N);
        repeat (10) step('0, 1'b1, ov, oi, oo);
        chk("fair_drained", ov, 0);

        // Random arrivals and backpressure.
        for (int c = 0; c < 400; c++)
            step(($urandom_range(0, 2) == 0) ? N'($urandom) : '0,
                 ($urandom_range(0, 3) != 0), ov, oi, oo);
        repeat (12) step('0, 1'b1, ov, oi, oo);
        chk("final_idle", ov, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
